// File: rtl/membus_arb.sv
// Two-port round-robin memory bus arbiter: port A (CPU) and port B (DMA/debug)
// share one memory; each transaction runs IDLE -> ACCESS (WAIT_CYCLES) -> DONE.
module membus_arb #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        b_req,
   input  logic [15:0] a_addr,
   input  logic [15:0] b_addr,
   input  logic        a_rw,
   input  logic        b_rw,
   input  logic [7:0]  a_wdata,
   input  logic [7:0]  b_wdata,
   output logic        a_gnt,
   output logic        b_gnt,
   output logic        a_ack,
   output logic        b_ack,
   output logic [7:0]  rdata,
   output logic        mem_en,
   output logic [15:0] mem_addr,
   output logic        mem_rw,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   localparam int unsigned   CNT_W    = 4;
   localparam int unsigned   ADDR_W   = 16;
   localparam int unsigned   DATA_W   = 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                owner_q, owner_d;     // 1 = port B owns the bus
   logic                last_b_q, last_b_d;   // 1 = port B was served last
   logic                a_gnt_q, a_gnt_d;
   logic                b_gnt_q, b_gnt_d;
   logic                a_ack_q, a_ack_d;
   logic                b_ack_q, b_ack_d;
   logic                mem_en_q, mem_en_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_rw_q, mem_rw_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                win_b;

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      last_b_d    = last_b_q;
      a_gnt_d     = 1'b0;
      b_gnt_d     = 1'b0;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      mem_en_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_rw_d    = mem_rw_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      win_b       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (a_req || b_req) begin
               // B wins if alone, or on a tie when A was served last
               win_b       = b_req && (!a_req || !last_b_q);
               owner_d     = win_b;
               mem_addr_d  = win_b ? b_addr  : a_addr;
               mem_rw_d    = win_b ? b_rw    : a_rw;
               mem_wdata_d = win_b ? b_wdata : a_wdata;
               cnt_d       = CNT_LOAD;
               mem_en_d    = 1'b1;
               a_gnt_d     = !win_b;
               b_gnt_d     = win_b;
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            a_gnt_d = !owner_q;
            b_gnt_d = owner_q;
            if (cnt_q == CNT_W'(1)) begin
               cnt_d   = '0;
               a_ack_d = !owner_q;
               b_ack_d = owner_q;
               if (!mem_rw_q) begin
                  rdata_d = mem_rdata;
               end
               state_d = S_DONE;
            end else begin
               cnt_d    = cnt_q - CNT_W'(1);
               mem_en_d = 1'b1;
            end
         end
         S_DONE: begin
            last_b_d = owner_q;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         last_b_q    <= 1'b1;
         a_gnt_q     <= 1'b0;
         b_gnt_q     <= 1'b0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_rw_q    <= 1'b0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         last_b_q    <= last_b_d;
         a_gnt_q     <= a_gnt_d;
         b_gnt_q     <= b_gnt_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_rw_q    <= mem_rw_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign a_gnt     = a_gnt_q;
   assign b_gnt     = b_gnt_q;
   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign mem_en    = mem_en_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rw    = mem_rw_q;
   assign mem_wdata = mem_wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_membus_arb.sv
// Scoreboard bench for membus_arb: predicted transactions are queued at issue
// time and checked against the memory-side activity and the ack pulse.
module tb_membus_arb;

   localparam int unsigned W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, b_req, a_rw, b_rw;
   logic [15:0] a_addr, b_addr;
   logic [7:0]  a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_ack, b_ack;
   logic [7:0]  rdata;
   logic        mem_en, mem_rw;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   // Latency-only instances for the extreme WAIT_CYCLES values
   logic        r1_a_req, r1_a_gnt, r1_b_gnt, r1_a_ack, r1_b_ack, r1_mem_en, r1_mem_rw;
   logic [15:0] r1_mem_addr;
   logic [7:0]  r1_mem_wdata, r1_rdata;
   logic        r15_a_req, r15_a_gnt, r15_b_gnt, r15_a_ack, r15_b_ack, r15_mem_en, r15_mem_rw;
   logic [15:0] r15_mem_addr;
   logic [7:0]  r15_mem_wdata, r15_rdata;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mem_fn(input logic [15:0] ad);
      if (ad == 16'h1234) return 8'hA5;
      return ad[7:0] ^ ad[15:8] ^ 8'h3C;
   endfunction

   assign mem_rdata = mem_fn(mem_addr);

   membus_arb #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .b_req(b_req), .a_addr(a_addr), .b_addr(b_addr),
      .a_rw(a_rw), .b_rw(b_rw), .a_wdata(a_wdata), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_ack(a_ack), .b_ack(b_ack),
      .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rw(mem_rw),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   membus_arb #(.WAIT_CYCLES(1)) dut_w1 (
      .clk(clk), .rst(rst),
      .a_req(r1_a_req), .b_req(1'b0), .a_addr(16'h0042), .b_addr(16'h0000),
      .a_rw(1'b0), .b_rw(1'b0), .a_wdata(8'h00), .b_wdata(8'h00),
      .a_gnt(r1_a_gnt), .b_gnt(r1_b_gnt), .a_ack(r1_a_ack), .b_ack(r1_b_ack),
      .rdata(r1_rdata), .mem_en(r1_mem_en), .mem_addr(r1_mem_addr), .mem_rw(r1_mem_rw),
      .mem_wdata(r1_mem_wdata), .mem_rdata(8'h77)
   );

   membus_arb #(.WAIT_CYCLES(15)) dut_w15 (
      .clk(clk), .rst(rst),
      .a_req(r15_a_req), .b_req(1'b0), .a_addr(16'h0042), .b_addr(16'h0000),
      .a_rw(1'b0), .b_rw(1'b0), .a_wdata(8'h00), .b_wdata(8'h00),
      .a_gnt(r15_a_gnt), .b_gnt(r15_b_gnt), .a_ack(r15_a_ack), .b_ack(r15_b_ack),
      .rdata(r15_rdata), .mem_en(r15_mem_en), .mem_addr(r15_mem_addr), .mem_rw(r15_mem_rw),
      .mem_wdata(r15_mem_wdata), .mem_rdata(8'h77)
   );

   typedef struct {
      logic        port;   // 1 = B
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   en_cnt = 0;
   logic m_last_b;
   logic [7:0] m_rdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory-side and ack monitor against the scoreboard
   initial forever begin
      exp_t e;
      @(negedge clk);
      chk("gnt_ack_exclusive", {a_gnt & b_gnt, a_ack & b_ack}, 2'b00);
      if (sb.size() == 0) begin
         chk("no_txn_activity", {mem_en, a_ack | b_ack}, 2'b00);
      end else begin
         if (mem_en) begin
            en_cnt++;
            chk("mem_addr", mem_addr, sb[0].addr);
            chk("mem_rw", mem_rw, sb[0].rw);
            chk("mem_wdata", mem_wdata, sb[0].wdata);
            chk("gnt_owner", {a_gnt, b_gnt}, sb[0].port ? 2'b01 : 2'b10);
         end
         if (a_ack | b_ack) begin
            e = sb.pop_front();
            chk("ack_port", {a_ack, b_ack}, e.port ? 2'b01 : 2'b10);
            chk("gnt_in_done", {a_gnt, b_gnt, mem_en}, e.port ? 3'b010 : 3'b100);
            chk("rdata", rdata, e.rdata);
            chk("access_len", en_cnt, W);
            en_cnt = 0;
         end
      end
   end

   // Drive a request pattern and push the predicted winning transaction
   task automatic start_txn(input logic ar, input logic br,
                            input logic [15:0] aa, input logic [15:0] ba,
                            input logic arw, input logic brw,
                            input logic [7:0] awd, input logic [7:0] bwd);
      exp_t e;
      logic wb;
      a_req = ar; b_req = br; a_addr = aa; b_addr = ba;
      a_rw = arw; b_rw = brw; a_wdata = awd; b_wdata = bwd;
      wb = br && (!ar || !m_last_b);
      e.port  = wb;
      e.addr  = wb ? ba  : aa;
      e.rw    = wb ? brw : arw;
      e.wdata = wb ? bwd : awd;
      if (!e.rw) m_rdata = mem_fn(e.addr);
      e.rdata = m_rdata;
      sb.push_back(e);
      m_last_b = wb;
   endtask

   task automatic wait_ack(output int ack_cyc);
      ack_cyc = -1;
      for (int i = 0; i < int'(W) + 6; i++) begin
         @(negedge clk);
         if (a_ack | b_ack) begin
            ack_cyc = cyc;
            break;
         end
      end
      if (ack_cyc < 0) chk("ack_timeout", a_ack | b_ack, 1'b1);
   endtask

   task automatic idle_bus();
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic meas(input logic sel15, output int lat);
      int t0;
      lat = -1;
      t0  = cyc;
      if (sel15) r15_a_req = 1'b1; else r1_a_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sel15 ? r15_a_ack : r1_a_ack) begin
            lat = cyc - t0 + 1;
            break;
         end
      end
      if (sel15) begin
         chk("w15_ack_seen", r15_a_ack, 1'b1);
         chk("w15_done_ctl", {r15_a_gnt, r15_b_gnt, r15_b_ack, r15_mem_en}, 4'b1000);
         chk("w15_mem_bus", {r15_mem_addr, r15_mem_rw, r15_mem_wdata}, {16'h0042, 1'b0, 8'h00});
         chk("w15_rdata", r15_rdata, 8'h77);
         r15_a_req = 1'b0;
      end else begin
         chk("w1_ack_seen", r1_a_ack, 1'b1);
         chk("w1_done_ctl", {r1_a_gnt, r1_b_gnt, r1_b_ack, r1_mem_en}, 4'b1000);
         chk("w1_mem_bus", {r1_mem_addr, r1_mem_rw, r1_mem_wdata}, {16'h0042, 1'b0, 8'h00});
         chk("w1_rdata", r1_rdata, 8'h77);
         r1_a_req = 1'b0;
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int c, prev, t0, lat;
      logic [7:0] held;
      rst = 1'b1;
      a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
      a_rw = 1'b0; b_rw = 1'b0; a_wdata = '0; b_wdata = '0;
      r1_a_req = 1'b0; r15_a_req = 1'b0;
      m_last_b = 1'b1;
      m_rdata  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {a_gnt, b_gnt, a_ack, b_ack, mem_en, mem_addr, mem_rw, mem_wdata, rdata}, 38'h0);
      rst = 1'b0;
      @(negedge clk);

      // Two continuous requesters: A first after reset, then strict alternation
      start_txn(1'b1, 1'b1, 16'h1234, 16'h0ABC, 1'b0, 1'b0, 8'h11, 8'h22);
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_ack(c);
         chk("rr_order", {a_ack, b_ack}, (i % 2 == 1) ? 2'b01 : 2'b10);
         if (i > 0) chk("rr_ack_gap", c - prev, W + 2);
         prev = c;
         if (i < 3) start_txn(1'b1, 1'b1, 16'h1234, 16'h0ABC, 1'b0, 1'b0, 8'h11, 8'h22);
      end
      idle_bus();

      // Single A read: latency and read data
      t0 = cyc;
      start_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00);
      wait_ack(c);
      chk("a_read_latency", c - t0 + 1, W + 2);
      chk("a_read_rdata", rdata, 8'hA5);
      idle_bus();

      // B write: rdata holds, memory bus holds after the access
      held = rdata;
      start_txn(1'b0, 1'b1, 16'h0000, 16'h00FF, 1'b0, 1'b1, 8'h00, 8'h3C);
      wait_ack(c);
      chk("b_write_rdata_hold", rdata, held);
      idle_bus();
      chk("mem_bus_hold_idle", {mem_en, mem_addr, mem_rw, mem_wdata}, {1'b0, 16'h00FF, 1'b1, 8'h3C});

      // Address change after grant is ignored
      start_txn(1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("a_gnt_first_access", {a_gnt, mem_en}, 2'b11);
      a_addr = 16'h2000;
      wait_ack(c);
      idle_bus();

      // Request dropped mid-access still completes
      start_txn(1'b0, 1'b1, 16'h0000, 16'h0203, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      b_req = 1'b0;
      wait_ack(c);
      chk("drop_req_ack", b_ack, 1'b1);
      idle_bus();

      // Mixed random traffic, chained back to back
      for (int i = 0; i < 10; i++) begin
         logic ar, br;
         ar = 1'($urandom_range(0, 1));
         br = ar ? 1'($urandom_range(0, 1)) : 1'b1;
         start_txn(ar, br, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         wait_ack(c);
      end
      idle_bus();

      // Reset during the first access cycle; held request restarts
      start_txn(1'b1, 1'b0, 16'h4321, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_outputs", {a_gnt, b_gnt, a_ack, b_ack, mem_en, mem_addr, mem_rw, mem_wdata, rdata}, 38'h0);
      sb.delete();
      en_cnt   = 0;
      m_last_b = 1'b1;
      m_rdata  = 8'h00;
      rst      = 1'b0;
      t0 = cyc;
      start_txn(1'b1, 1'b0, 16'h4321, 16'h0000, 1'b0, 1'b0, 8'h00, 8'h00);
      wait_ack(c);
      chk("rst_restart_latency", c - t0 + 1, W + 2);
      idle_bus();

      // Extreme WAIT_CYCLES builds
      meas(1'b0, lat);
      chk("w1_latency", lat, 3);
      meas(1'b1, lat);
      chk("w15_latency", lat, 17);

      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/membus_arb.md
MEMBUS_ARB -- requirements
Module: membus_arb

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: memory access cycles per transaction; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports a_req, input, 1 and b_req, input, 1: access requests; port A is CPU, port B is DMA/debug.
REQ-005 SHALL have ports a_addr, input, 16 and b_addr, input, 16: access addresses.
REQ-006 SHALL have ports a_rw, input, 1 and b_rw, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports a_wdata, input, 8 and b_wdata, input, 8: write data.
REQ-008 SHALL have ports a_gnt, output, 1 and b_gnt, output, 1: high while that port owns the memory bus.
REQ-009 SHALL have ports a_ack, output, 1 and b_ack, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 8: read data; valid in the cycle an ack is high.
REQ-011 SHALL have ports mem_en, output, 1; mem_addr, output, 16; mem_rw, output, 1; mem_wdata, output, 8: memory-side access.
REQ-012 SHALL have port mem_rdata, input, 8: memory read data, sampled on the last access cycle.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-014 IDLE: no request -> stay in IDLE; one or more requests -> select winner, latch its addr/rw/wdata, go to ACCESS, assert winner's gnt starting next cycle.
REQ-015 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the port not served last wins.
REQ-016 ACCESS: mem_en=1; mem_addr/mem_rw/mem_wdata driven from latched values; SHALL last exactly WAIT_CYCLES cycles (4-bit down-counter).
REQ-017 The last ACCESS cycle SHALL capture mem_rdata into rdata for reads; for writes rdata SHALL hold its previous value.
REQ-018 DONE: one cycle; mem_en=0; winner's ack=1; gnt stays high; last-served pointer updated to winner; go to IDLE.
REQ-019 Latency from req sampled in IDLE to ack SHALL be WAIT_CYCLES+2 cycles; a port requesting continuously, with the other port idle, SHALL get back-to-back transactions every WAIT_CYCLES+2 cycles.
REQ-020 Requests seen in ACCESS or DONE SHALL NOT alter the transaction in flight; a changed address/data after grant SHALL be ignored because the values are latched.
REQ-021 A req deasserted during ACCESS SHALL NOT abort the access; the access SHALL complete and ack SHALL still pulse.
REQ-022 a_gnt and b_gnt SHALL never both be 1; a_ack and b_ack SHALL never both be 1.
REQ-023 mem_en SHALL be 0 in IDLE and DONE; mem_addr/mem_rw/mem_wdata SHALL hold their last values when mem_en=0.
REQ-024 Under two continuous requesters, grants SHALL alternate A,B,A,B; neither port SHALL wait more than one full transaction.

Reset
REQ-025 On rst=1 at posedge clk: state=IDLE; counter=0; all gnt/ack=0; mem_en=0; mem_addr=0; mem_rw=0; mem_wdata=0; rdata=0; last-served=B, so A wins the first tie.
REQ-026 rst SHALL override any in-flight access; no ack SHALL follow a reset, and the aborted request SHALL be re-arbitrated if still asserted.

Verification
REQ-027 Single A read, WAIT_CYCLES=2: a_req=1, a_addr=16'h1234, a_rw=0, mem returns 8'hA5 -> mem_en high 2 cycles at 16'h1234; a_ack pulses at cycle 4 with rdata=8'hA5.
REQ-028 Simultaneous requests after reset: a_req=b_req=1 held -> grant order A,B,A,B; each ack spaced 4 cycles apart; gnts never overlap.
REQ-029 B write: b_addr=16'h00FF, b_wdata=8'h3C, b_rw=1 -> mem_rw=1, mem_wdata=8'h3C for 2 cycles; b_ack pulses; rdata unchanged.
REQ-030 Address changed mid-ACCESS: a_addr switches 16'h1000->16'h2000 one cycle after a_gnt -> mem_addr stays 16'h1000 for the whole access.
REQ-031 Reset mid-ACCESS: rst=1 during the first ACCESS cycle -> next cycle all outputs are at reset values; no ack occurs; a held request restarts and completes normally.
REQ-032 WAIT_CYCLES=1 and WAIT_CYCLES=15 builds: measured req-to-ack latency is 3 and 17 cycles respectively.
